// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code receiver.
package ps2_pkg;
  localparam int FRAME_BITS = 11;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] PS2_IGN_ERR0  = 8'h00;
  localparam logic [7:0] PS2_IGN_BAT   = 8'hAA;
  localparam logic [7:0] PS2_IGN_ECHO  = 8'hEE;
  localparam logic [7:0] PS2_IGN_ACK   = 8'hFA;
  localparam logic [7:0] PS2_IGN_RESND = 8'hFE;
  localparam logic [7:0] PS2_IGN_ERR1  = 8'hFF;

  typedef enum logic [1:0] {IDLE, RX, CHECK} ps2_state_e;

  // Keyboard housekeeping bytes that never represent a keystroke.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_IGN_ERR0) || (b == PS2_IGN_BAT)   || (b == PS2_IGN_ECHO) ||
           (b == PS2_IGN_ACK)  || (b == PS2_IGN_RESND) || (b == PS2_IGN_ERR1);
  endfunction
endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 pin synchroniser, ps2_clk glitch filter and falling-edge tick.
module ps2_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_tick,
  output logic data_sync
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic [CW-1:0]          cnt;
  logic                   filt;
  logic                   clk_s;

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign data_sync = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      dat_sync  <= '1;
      cnt       <= '0;
      filt      <= 1'b1;
      fall_tick <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      fall_tick <= 1'b0;
      // Level only flips after FILTER_LEN consecutive disagreeing samples.
      if (clk_s != filt) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          filt      <= clk_s;
          cnt       <= '0;
          fall_tick <= filt & ~clk_s;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: frames, E0/F0 prefix resolution, make/break strobes.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses typematic repeats of the held key.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] last_change,
  output logic       key_valid,
  output logic [8:0] release_code,
  output logic       key_release,
  output logic       key_down,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_e  state, state_nxt;
  logic        fall_tick, data_s;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit, stop_bit;
  logic        ext_flag, brk_flag;
  logic [TW-1:0] timer;
  logic        counting, timeout, frame_ok, repeat_hit;
  logic [8:0]  code;

  ps2_clk_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fall_tick (fall_tick),
    .data_sync (data_s)
  );

  assign counting = (state == RX) || ((state == IDLE) && (ext_flag || brk_flag));
  assign timeout  = counting && !fall_tick && (timer == TW'(TIMEOUT_CYC - 1));
  assign frame_ok = (^{shreg, par_bit}) && stop_bit;
  assign code     = {ext_flag, shreg};

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign repeat_hit = key_down && (code == last_change);
`else
  assign repeat_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall_tick && !data_s) state_nxt = RX;
      RX: begin
        if (timeout)                                           state_nxt = IDLE;
        else if (fall_tick && bit_cnt == 4'(FRAME_BITS - 2))   state_nxt = CHECK;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      stop_bit     <= 1'b0;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      timer        <= '0;
      last_change  <= '0;
      release_code <= '0;
      key_valid    <= 1'b0;
      key_release  <= 1'b0;
      key_down     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      frame_err   <= 1'b0;

      if (fall_tick || !counting) timer <= '0;
      else                        timer <= timer + TW'(1);

      if (timeout) begin
        bit_cnt  <= '0;
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: if (fall_tick && !data_s) bit_cnt <= '0;
          RX: if (fall_tick) begin
            // bit_cnt 0..7 data LSB first, 8 parity, 9 stop.
            if (bit_cnt < 4'd8)       shreg    <= {data_s, shreg[7:1]};
            else if (bit_cnt == 4'd8) par_bit  <= data_s;
            else                      stop_bit <= data_s;
            bit_cnt <= bit_cnt + 4'd1;
          end
          CHECK: begin
            if (!frame_ok) begin
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end else if (shreg == PS2_PREFIX_EXT) begin
              ext_flag <= 1'b1;
            end else if (shreg == PS2_PREFIX_BRK) begin
              brk_flag <= 1'b1;
            end else if (!is_ignored(shreg)) begin
              if (brk_flag) begin
                release_code <= code;
                key_release  <= 1'b1;
                if (code == last_change) key_down <= 1'b0;
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
              end else begin
                if (!repeat_hit) begin
                  last_change <= code;
                  key_valid   <= 1'b1;
                  key_down    <= 1'b1;
                end
                ext_flag <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench for ps2_scan_receiver: directed PS/2 frames, monitor-side checking.
module tb_ps2_scan_receiver;
  localparam int TO   = 2000;
  localparam int HALF = 50;

  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [8:0] last_change, release_code;
  logic key_valid, key_release, key_down, frame_err;

  ps2_scan_receiver #(.SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .last_change  (last_change),
    .key_valid    (key_valid),
    .release_code (release_code),
    .key_release  (key_release),
    .key_down     (key_down),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_MAKE, EV_BRK, EV_ERR} ev_e;
  typedef struct {
    ev_e        kind;
    logic [8:0] lc;
    logic [8:0] rc;
    logic       kd;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_e k, input logic [8:0] lc, input logic [8:0] rc,
                           input logic kd);
    ev_t e;
    e.kind = k; e.lc = lc; e.rc = rc; e.kd = kd;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe pops one expected event.
  always @(negedge clk) begin
    if (rst_n && (key_valid || key_release || frame_err)) begin
      ev_t  e;
      logic [1:0] k;
      chk("one_strobe", 9'(int'(key_valid) + int'(key_release) + int'(frame_err)), 9'd1);
      k = key_valid ? 2'(EV_MAKE) : key_release ? 2'(EV_BRK) : 2'(EV_ERR);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d lc %h rc %h, required none", k,
                 last_change, release_code);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind",   9'(k), 9'(e.kind));
        chk("last_change",  last_change, e.lc);
        chk("release_code", release_code, e.rc);
        chk("key_down",     9'(key_down), 9'(e.kd));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_par);
    logic p;
    p = good_par ? ~^b : ^b;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    wait_cyc(40);
    while (exp_q.size() != 0 && n < 5000) begin
      wait_cyc(1);
      n++;
    end
    chk(name, 9'(exp_q.size()), 9'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_last_change"},  last_change,  9'h000);
    chk({tag, "_release_code"}, release_code, 9'h000);
    chk({tag, "_key_valid"},    9'(key_valid),   9'd0);
    chk({tag, "_key_release"},  9'(key_release), 9'd0);
    chk({tag, "_key_down"},     9'(key_down),    9'd0);
    chk({tag, "_frame_err"},    9'(frame_err),   9'd0);
  endtask

  initial begin
    wait_cyc(5);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    wait_cyc(20);

    // Plain make
    expect_ev(EV_MAKE, 9'h016, 9'h000, 1'b1);
    send_byte(8'h16, 1'b1);
    drain("drain_make16");

    // Break of the same key
    expect_ev(EV_BRK, 9'h016, 9'h016, 1'b0);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h16, 1'b1);
    drain("drain_brk16");

    // Extended make and break
    expect_ev(EV_MAKE, 9'h15A, 9'h016, 1'b1);
    send_byte(8'hE0, 1'b1);
    send_byte(8'h5A, 1'b1);
    drain("drain_make15a");
    expect_ev(EV_BRK, 9'h15A, 9'h15A, 1'b0);
    send_byte(8'hE0, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h5A, 1'b1);
    drain("drain_brk15a");

    // Parity error then a good frame
    expect_ev(EV_ERR, 9'h15A, 9'h15A, 1'b0);
    send_byte(8'h1E, 1'b0);
    drain("drain_parerr");
    expect_ev(EV_MAKE, 9'h01E, 9'h15A, 1'b1);
    send_byte(8'h1E, 1'b1);
    drain("drain_make01e");

    // Partial frame abandoned by timeout
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    wait_cyc(TO + 10);
    expect_ev(EV_MAKE, 9'h026, 9'h15A, 1'b1);
    send_byte(8'h26, 1'b1);
    drain("drain_to_frame");

    // Release, then a stale E0 prefix dropped by timeout
    expect_ev(EV_BRK, 9'h026, 9'h026, 1'b0);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h26, 1'b1);
    drain("drain_brk026");
    send_byte(8'hE0, 1'b1);
    wait_cyc(TO + 10);
    expect_ev(EV_MAKE, 9'h026, 9'h026, 1'b1);
    send_byte(8'h26, 1'b1);
    drain("drain_to_prefix");

    // Typematic repeats
    expect_ev(EV_MAKE, 9'h025, 9'h026, 1'b1);
`ifndef PS2_TYPEMATIC_FILTER_EN
    expect_ev(EV_MAKE, 9'h025, 9'h026, 1'b1);
    expect_ev(EV_MAKE, 9'h025, 9'h026, 1'b1);
`endif
    send_byte(8'h25, 1'b1);
    send_byte(8'h25, 1'b1);
    send_byte(8'h25, 1'b1);
    drain("drain_repeat");

    // Reset mid-frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    wait_cyc(5);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    chk_reset_vals("midrst");
    wait_cyc(50);
    expect_ev(EV_MAKE, 9'h045, 9'h000, 1'b1);
    send_byte(8'h45, 1'b1);
    drain("drain_make045");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
